ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single data RAM between two requesters: port 0 is the CPU load/store path, port 1 is the UART debug loader.
//  The debug loader uses port 1 to inspect and patch data memory.
//  Each port has a valid/grant command interface; every cycle the arbiter issues at most one command to the RAM.
//  Read data is routed back to the issuing port one cycle later.
//  Arbitration is round-robin with a bounded lock, so neither requester can starve the other.
// PARAMETERS
//  LOCK_MAX  16  max consecutive grants a locked port keeps while the other port is requesting (>=1)
//  CNT_W     5   width of the lock counter; must hold LOCK_MAX
// PORTS
//  clk          input   1   system clock
//  rst          input   1   asynchronous reset, active-high
//  m0_req_i     input   1   port 0 (CPU) command valid
//  m0_we_i      input   1   1 = write, 0 = read
//  m0_sel_i     input   4   byte write enables (ignored on read)
//  m0_addr_i    input   32  byte address
//  m0_wdata_i   input   32  write data
//  m0_lock_i    input   1   keep grant on consecutive cycles (burst)
//  m0_gnt_o     output  1   command accepted this cycle
//  m0_rvalid_o  output  1   m0_rdata_o valid (read issued previous cycle)
//  m0_rdata_o   output  32  read data
//  m1_*                     same set of signals for port 1 (debug loader)
//  ram_wen_o    output  4   RAM byte write enables
//  ram_waddr_o  output  32  RAM write address
//  ram_wdata_o  output  32  RAM write data
//  ram_ren_o    output  1   RAM read enable
//  ram_raddr_o  output  32  RAM read address
//  ram_rdata_i  input   32  RAM read data; synchronous, valid 1 cycle after ram_ren_o
// BEHAVIOUR
//  - Reset state: all gnt/rvalid/ram_wen/ram_ren outputs 0, all address/data outputs 0, lock counter 0.
//    last_owner resets to 1, so port 0 wins the first tie.
//  - Grant logic is combinational in the request cycle.
//    - Exactly one of m0_gnt_o/m1_gnt_o is high when any req is high; both are low when no req is high.
//    - gnt never rises without its req.
//  - Winner selection:
//    - Only one req high -> that port wins.
//    - Both reqs high, no active lock -> the port != last_owner wins.
//  - Lock:
//    - Active lock: last_owner req AND lock_i both high, and lock_cnt < LOCK_MAX -> last_owner wins again.
//    - lock_cnt increments on each grant taken under lock while the other port is requesting.
//    - lock_cnt clears when ownership changes or when the owner drops lock_i or req.
//    - With the other port idle, the counter does not advance and the lock is unlimited.
//  - Command mapping for the winning port:
//    - Write (we=1): ram_wen_o = sel, ram_waddr_o = addr, ram_wdata_o = wdata; ram_ren_o = 0.
//    - Read (we=0): ram_ren_o = 1, ram_raddr_o = addr; ram_wen_o = 0.
//    - No grant: ram_wen_o = 0 and ram_ren_o = 0.
//  - Read return:
//    - rd_owner and rd_pend are registered on a granted read.
//    - Next cycle: mX_rvalid_o = 1 for rd_owner only, mX_rdata_o = ram_rdata_i.
//    - The non-owner port's rvalid stays 0 and its rdata holds its last value.
//    - Back-to-back reads from alternating ports return in issue order, one per cycle.
//  - Write-then-read to the same address on consecutive cycles returns the new data; this relies on RAM write-first ordering.
//  - last_owner updates on every grant; the FSM states are IDLE/OWN0/OWN1 and are encoded by last_owner plus an any-grant flag.
//  - Reset asserted mid-operation: the pending rvalid is dropped immediately (async) and no rvalid is emitted after reset release.
//  - A requester must hold req and its command stable until gnt; commands change only after gnt.
// TESTING
//  - Reset, then m0 reads 0x10 (RAM holds 0xDEADBEEF):
//    -> m0_gnt_o=1 in the same cycle, ram_ren_o=1, raddr=0x10.
//    -> Next cycle m0_rvalid_o=1, m0_rdata_o=0xDEADBEEF, m1_rvalid_o=0.
//  - Both ports request continuously, no lock:
//    -> Grants go m0,m1,m0,m1...
//    -> Each rvalid reaches the correct port one cycle later.
//  - m1 holds lock+req for 40 cycles while m0 requests, LOCK_MAX=16:
//    -> m1 gets 16 grants, then m0 gets 1, then m1 resumes.
//    -> m0 never waits more than 16 cycles.
//  - m0 writes 0xA5A5A5A5 with sel=4'b0011 to 0x20, then m1 reads 0x20:
//    -> ram_wen_o=4'b0011.
//    -> m1_rdata_o low halfword = 0xA5A5.
//  - rst pulsed in the cycle after a granted read:
//    -> Both rvalid outputs drop to 0 at once.
//    -> No rvalid appears after release.
//  - No requests for 10 cycles:
//    -> gnt, ram_wen_o and ram_ren_o stay 0.
//    -> last_owner is unchanged.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous data RAM.
// Port 0 is the CPU load/store path, port 1 the UART debug loader; bounded burst lock.
`timescale 1ns/1ps
module ram_arbiter #(
  parameter int LOCK_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_lock_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_lock_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic [3:0]  ram_wen_o,
  output logic [31:0] ram_waddr_o,
  output logic [31:0] ram_wdata_o,
  output logic        ram_ren_o,
  output logic [31:0] ram_raddr_o,
  input  logic [31:0] ram_rdata_i,
  output logic [1:0]  dbg_state_o,
  output logic        dbg_last_owner_o
);

  // Handshake: a port raises req with a stable command; the command is taken in the
  // cycle gnt is high (same cycle, combinational). Read data returns one cycle later
  // with rvalid; there is no back-pressure on the read return.

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} arb_state_t;

  arb_state_t       state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             rd_pend_q, rd_owner_q;
  logic [31:0]      rdata0_q, rdata1_q;

  logic        any_req, lock_act, winner, other_req;
  logic        win_we, win_lock;
  logic [3:0]  win_sel;
  logic [31:0] win_addr, win_wdata;

  always_comb begin
    any_req      = (m0_req_i | m1_req_i) & ~rst;
    lock_act     = (last_owner_q ? (m1_req_i & m1_lock_i) : (m0_req_i & m0_lock_i))
                   && (lock_cnt_q < CNT_W'(LOCK_MAX));
    winner       = m1_req_i;
    if (m0_req_i && m1_req_i) winner = lock_act ? last_owner_q : ~last_owner_q;

    other_req    = winner ? m0_req_i : m1_req_i;
    win_we       = winner ? m1_we_i    : m0_we_i;
    win_lock     = winner ? m1_lock_i  : m0_lock_i;
    win_sel      = winner ? m1_sel_i   : m0_sel_i;
    win_addr     = winner ? m1_addr_i  : m0_addr_i;
    win_wdata    = winner ? m1_wdata_i : m0_wdata_i;

    m0_gnt_o     = any_req & ~winner;
    m1_gnt_o     = any_req & winner;
    ram_wen_o    = 4'b0000;
    ram_waddr_o  = '0;
    ram_wdata_o  = '0;
    ram_ren_o    = 1'b0;
    ram_raddr_o  = '0;
    if (any_req && win_we) begin
      ram_wen_o   = win_sel;
      ram_waddr_o = win_addr;
      ram_wdata_o = win_wdata;
    end else if (any_req) begin
      ram_ren_o   = 1'b1;
      ram_raddr_o = win_addr;
    end

    state_d      = IDLE;
    last_owner_d = last_owner_q;
    if (any_req) begin
      state_d      = winner ? OWN1 : OWN0;
      last_owner_d = winner;
    end

    // A grant that changes ownership starts a new locked run at 1, so the waiting
    // port sees at most LOCK_MAX consecutive grants to the other side.
    lock_cnt_d = '0;
    if (any_req && win_lock) begin
      if (winner != last_owner_q) lock_cnt_d = other_req ? CNT_W'(1) : '0;
      else if (other_req)         lock_cnt_d = lock_cnt_q + CNT_W'(1);
      else                        lock_cnt_d = lock_cnt_q;
    end
  end

  assign m0_rvalid_o      = rd_pend_q & ~rd_owner_q;
  assign m1_rvalid_o      = rd_pend_q & rd_owner_q;
  assign m0_rdata_o       = m0_rvalid_o ? ram_rdata_i : rdata0_q;
  assign m1_rdata_o       = m1_rvalid_o ? ram_rdata_i : rdata1_q;
  assign dbg_state_o      = state_q;
  assign dbg_last_owner_o = last_owner_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      lock_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_pend_q    <= any_req & ~win_we;
      rd_owner_q   <= winner;
      if (m0_rvalid_o) rdata0_q <= ram_rdata_i;
      if (m1_rvalid_o) rdata1_q <= ram_rdata_i;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: per-cycle grant/command expectations and per-port
// read-data queues are checked by a negedge monitor against a behavioural RAM.
`timescale 1ns/1ps
module tb_ram_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  ram_wen;
  logic [31:0] ram_waddr, ram_wdata, ram_raddr, ram_rdata;
  logic        ram_ren;
  logic [1:0]  dbg_state;
  logic        dbg_last_owner;

  ram_arbiter #(.LOCK_MAX(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_lock_i(m0_lock), .m0_gnt_o(m0_gnt),
    .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt),
    .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_wen_o(ram_wen), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
    .ram_ren_o(ram_ren), .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata),
    .dbg_state_o(dbg_state), .dbg_last_owner_o(dbg_last_owner)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural RAM (write-first, 1-cycle read) ----------------
  logic [31:0] mem [int];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(posedge clk) begin
    logic [31:0] cur;
    if (ram_wen != 4'b0000) begin
      cur = mem.exists(int'(ram_waddr[31:2])) ? mem[int'(ram_waddr[31:2])] : init_val(ram_waddr);
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) cur[8*b +: 8] = ram_wdata[8*b +: 8];
      mem[int'(ram_waddr[31:2])] = cur;
    end
    if (ram_ren)
      ram_rdata <= mem.exists(int'(ram_raddr[31:2])) ? mem[int'(ram_raddr[31:2])] : init_val(ram_raddr);
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]  rv;
    logic [1:0]  gnt;
    logic        ren;
    logic [3:0]  wen;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } cyc_t;

  cyc_t        exp_cyc_q[$];
  logic [31:0] exp_rd0_q[$];
  logic [31:0] exp_rd1_q[$];
  logic [1:0]  prev_rv;
  int          n_checks, n_fail;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] hold0, hold1;

  always @(negedge clk) begin
    cyc_t e, a;
    logic [31:0] d;
    a = '{rv: {m1_rvalid, m0_rvalid}, gnt: {m1_gnt, m0_gnt}, ren: ram_ren, wen: ram_wen,
          raddr: ram_raddr, waddr: ram_waddr, wdata: ram_wdata};
    if (exp_cyc_q.size() > 0) begin
      e = exp_cyc_q.pop_front();
      check("cycle", 128'(a), 128'(e));
    end else begin
      check("rvalid_idle", 128'({m1_rvalid, m0_rvalid}), 128'(2'b00));
    end
    if (rst) begin
      hold0 = '0;
      hold1 = '0;
    end
    if (m0_rvalid && exp_rd0_q.size() > 0) begin
      d = exp_rd0_q.pop_front();
      check("m0_rdata", 128'(m0_rdata), 128'(d));
      hold0 = d;
    end else if (!m0_rvalid) begin
      check("m0_rdata_hold", 128'(m0_rdata), 128'(hold0));
    end
    if (m1_rvalid && exp_rd1_q.size() > 0) begin
      d = exp_rd1_q.pop_front();
      check("m1_rdata", 128'(m1_rdata), 128'(d));
      hold1 = d;
    end else if (!m1_rvalid) begin
      check("m1_rdata_hold", 128'(m1_rdata), 128'(hold1));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic cyc_t rd_exp(input int p, input logic [31:0] a);
    cyc_t e = '0;
    e.gnt   = (p == 1) ? 2'b10 : 2'b01;
    e.ren   = 1'b1;
    e.raddr = a;
    return e;
  endfunction

  function automatic cyc_t wr_exp(input int p, input logic [3:0] s, input logic [31:0] a,
                                  input logic [31:0] d);
    cyc_t e = '0;
    e.gnt   = (p == 1) ? 2'b10 : 2'b01;
    e.wen   = s;
    e.waddr = a;
    e.wdata = d;
    return e;
  endfunction

  task automatic step(input cyc_t e, input logic [31:0] rd_data);
    cyc_t x = e;
    x.rv    = prev_rv;
    prev_rv = x.ren ? x.gnt : 2'b00;
    if (x.ren && x.gnt[1]) exp_rd1_q.push_back(rd_data);
    else if (x.ren)        exp_rd0_q.push_back(rd_data);
    exp_cyc_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
    if (p == 0) begin
      m0_req = req; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
    end else begin
      m1_req = req; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a0, a1;
    int w;
    n_checks = 0; n_fail = 0; prev_rv = 2'b00; hold0 = '0; hold1 = '0;
    rst = 1'b1;
    set_port(0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    set_port(1, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_gnt",    128'({m1_gnt, m0_gnt}), 128'(2'b00));
    check("rst_rvalid", 128'({m1_rvalid, m0_rvalid}), 128'(2'b00));
    check("rst_ram",    128'({ram_wen, ram_ren, ram_waddr, ram_wdata, ram_raddr}), 128'(0));
    check("rst_rdata",  128'({m1_rdata, m0_rdata}), 128'(0));
    check("rst_owner",  128'({dbg_state, dbg_last_owner}), 128'({2'd0, 1'b1}));

    // single read from port 0
    set_port(0, 1, 0, 4'hF, 32'h10, 32'h0, 0);
    step(rd_exp(0, 32'h10), 32'hDEADBEEF);
    set_port(0, 0, 0, 4'h0, 32'h0, 32'h0, 0);

    // both ports read continuously, no lock: last_owner is 0 so m1 goes first
    a0 = 32'h100; a1 = 32'h200;
    for (int k = 0; k < 6; k++) begin
      set_port(0, 1, 0, 4'h0, a0, 32'h0, 0);
      set_port(1, 1, 0, 4'h0, a1, 32'h0, 0);
      w = (k % 2 == 0) ? 1 : 0;
      if (w == 1) begin step(rd_exp(1, a1), {16'hC0DE, a1[15:0]}); a1 += 4; end
      else        begin step(rd_exp(0, a0), {16'hC0DE, a0[15:0]}); a0 += 4; end
    end

    // m1 locked for 40 cycles against a continuously requesting m0
    a0 = 32'h180; a1 = 32'h300;
    for (int k = 0; k < 40; k++) begin
      set_port(0, 1, 0, 4'h0, a0, 32'h0, 0);
      set_port(1, 1, 0, 4'h0, a1, 32'h0, 1);
      if (k % 17 == 16) begin step(rd_exp(0, a0), {16'hC0DE, a0[15:0]}); a0 += 4; end
      else              begin step(rd_exp(1, a1), {16'hC0DE, a1[15:0]}); a1 += 4; end
    end
    // m1 alone: lock unlimited and the count (6) holds, so 10 more grants follow
    set_port(0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    for (int k = 0; k < 20; k++) begin
      set_port(1, 1, 0, 4'h0, a1, 32'h0, 1);
      step(rd_exp(1, a1), {16'hC0DE, a1[15:0]}); a1 += 4;
    end
    for (int k = 0; k < 12; k++) begin
      set_port(0, 1, 0, 4'h0, a0, 32'h0, 0);
      set_port(1, 1, 0, 4'h0, a1, 32'h0, 1);
      if (k == 10) begin step(rd_exp(0, a0), {16'hC0DE, a0[15:0]}); a0 += 4; end
      else         begin step(rd_exp(1, a1), {16'hC0DE, a1[15:0]}); a1 += 4; end
    end
    set_port(0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    set_port(1, 0, 0, 4'h0, 32'h0, 32'h0, 0);

    // partial write from m0, then m1 reads it back on the next cycle
    set_port(0, 1, 1, 4'b0011, 32'h20, 32'hA5A5A5A5, 0);
    step(wr_exp(0, 4'b0011, 32'h20, 32'hA5A5A5A5), 32'h0);
    set_port(0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    set_port(1, 1, 0, 4'h0, 32'h20, 32'h0, 0);
    step(rd_exp(1, 32'h20), 32'hC0DEA5A5);
    set_port(1, 0, 0, 4'h0, 32'h0, 32'h0, 0);

    // ten idle cycles: nothing granted, owner stays port 1
    for (int k = 0; k < 10; k++) step('0, 32'h0);
    check("idle_owner", 128'({dbg_state, dbg_last_owner}), 128'({2'd0, 1'b1}));

    // async reset while a read return is pending
    set_port(0, 1, 0, 4'h0, 32'h10, 32'h0, 0);
    step(rd_exp(0, 32'h10), 32'hDEADBEEF);
    set_port(0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    check("pre_rst_rvalid", 128'({m1_rvalid, m0_rvalid}), 128'(2'b01));
    check("pre_rst_rdata",  128'(m0_rdata), 128'(32'hDEADBEEF));
    rst = 1'b1;
    exp_rd0_q.delete();
    prev_rv = 2'b00;
    #1;
    check("rst_drop_rvalid", 128'({m1_rvalid, m0_rvalid}), 128'(2'b00));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_owner", 128'({dbg_state, dbg_last_owner}), 128'({2'd0, 1'b1}));
    for (int k = 0; k < 3; k++) step('0, 32'h0);

    @(negedge clk);
    check("queues_drained",
          128'({exp_cyc_q.size() == 0, exp_rd0_q.size() == 0, exp_rd1_q.size() == 0}),
          128'(3'b111));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
